cia_timer_bank: RTL

Parametrised bank of CIA-style interval timers. It generalises the two fixed 16-bit timers of the CIA to NUM_TIMERS channels of WIDTH bits, and adds external-count and cascaded-count input modes, per-timer PB-style outputs (pulse or toggle), and its own interrupt status/mask register. It sits on the same 6800-style chip bus as the CIA register file, clocked by E_CLK.

---
 rtl/cia_timer_bank.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cia_timer_bank.sv
// Bank of CIA-style interval timers with external-count and cascade modes,
// per-timer pulse/toggle outputs and a shared interrupt status/mask register.
module cia_timer_bank #(
    parameter int NUM_TIMERS = 2,
    parameter int WIDTH      = 16,
    parameter int TW         = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
    input  logic                  E_CLK,
    input  logic                  RESET_n,
    input  logic                  CS_n,
    input  logic                  RW,
    input  logic [TW+3:0]         A,
    input  logic [7:0]            D_IN,
    output logic [7:0]            D_OUT,
    input  logic [NUM_TIMERS-1:0] CNT,
    output logic [NUM_TIMERS-1:0] TOUT,
    output logic [NUM_TIMERS-1:0] TOUT_OE,
    output logic                  IRQ_n
);

    localparam int N  = NUM_TIMERS;
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] latch    [N];
    logic [WIDTH-1:0] count    [N];
    logic [WIDTH-1:0] top_load [N];
    logic [1:0]       inmode   [N];

    logic [N-1:0] start;
    logic [N-1:0] pbon;
    logic [N-1:0] outmode;
    logic [N-1:0] oneshot;
    logic [N-1:0] tog;
    logic [N-1:0] pulse;
    logic [N-1:0] mask;
    logic [N-1:0] status;
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] sync3;
    logic [N-1:0] tick;
    logic [N-1:0] uf;
    logic [N-1:0] hit;

    logic          wr;
    logic          rd;
    logic          sel_icr;
    logic [TW-1:0] idx;
    logic [2:0]    rsel;
    logic          ir;

    assign wr      = !CS_n && !RW;
    assign rd      = !CS_n && RW;
    assign sel_icr = A[TW+3];
    assign idx     = A[TW+2:3];
    assign rsel    = A[2:0];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            hit[i]      = !sel_icr && (idx == TW'(i));
            top_load[i] = latch[i];
            top_load[i][WIDTH-8 +: 8] = D_IN;
        end
    end

    // Walk the bank in index order so a cascade chain settles in one pass.
    always_comb begin
        logic carry;
        carry = 1'b0;
        tick  = '0;
        uf    = '0;
        for (int i = 0; i < N; i++) begin
            case (inmode[i])
                2'b00: tick[i] = 1'b1;
                2'b01: tick[i] = sync2[i] && !sync3[i];
                2'b10: tick[i] = (i == 0) ? 1'b1 : carry;
                2'b11: tick[i] = (i == 0) ? 1'b1 : (carry && sync2[i]);
                default: tick[i] = 1'b0;
            endcase
            uf[i] = start[i] && tick[i] && (count[i] == '0);
            carry = uf[i];
        end
    end

    always_ff @(negedge E_CLK) begin
        if (!RESET_n) begin
            for (int i = 0; i < N; i++) begin
                latch[i]  <= '0;
                count[i]  <= '0;
                inmode[i] <= '0;
            end
            start   <= '0;
            pbon    <= '0;
            outmode <= '0;
            oneshot <= '0;
            tog     <= '0;
            pulse   <= '0;
            mask    <= '0;
            status  <= '0;
            sync1   <= '0;
            sync2   <= '0;
            sync3   <= '0;
        end else begin
            sync1 <= CNT;
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= uf;
            for (int i = 0; i < N; i++) begin
                if (wr && hit[i] && rsel == 3'd7) begin
                    start[i]   <= D_IN[0];
                    pbon[i]    <= D_IN[1];
                    outmode[i] <= D_IN[2];
                    oneshot[i] <= D_IN[3];
                    inmode[i]  <= D_IN[6:5];
                end else if (uf[i] && oneshot[i]) begin
                    start[i] <= 1'b0;
                end

                for (int k = 0; k < NB; k++) begin
                    if (wr && hit[i] && rsel == 3'(k)) begin
                        latch[i][8*k +: 8] <= D_IN;
                    end
                end

                if (wr && hit[i] && rsel == 3'd7 && D_IN[4]) begin
                    count[i] <= latch[i];
                end else if (wr && hit[i] && rsel == 3'(NB-1)
                             && !start[i]) begin
                    count[i] <= top_load[i];
                end else if (start[i] && tick[i]) begin
                    count[i] <= uf[i] ? latch[i] : count[i] - 1'b1;
                end

                if (wr && hit[i] && rsel == 3'd7 && D_IN[0] && !start[i]) begin
                    tog[i] <= 1'b1;
                end else if (uf[i]) begin
                    tog[i] <= !tog[i];
                end
            end

            if (wr && sel_icr) begin
                mask <= D_IN[7] ? (mask | D_IN[N-1:0])
                                : (mask & ~D_IN[N-1:0]);
            end
            // A read hands back the old status; this edge's underflows stay.
            status <= (rd && sel_icr) ? uf : (status | uf);
        end
    end

    assign ir      = |(status & mask);
    assign IRQ_n   = !ir;
    assign TOUT    = (outmode & tog) | (~outmode & pulse);
    assign TOUT_OE = pbon;

    always_comb begin
        D_OUT = 8'h00;
        if (rd) begin
            if (sel_icr) begin
                D_OUT[N-1:0] = status;
                D_OUT[7]     = ir;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (hit[i]) begin
                        if (rsel == 3'd7) begin
                            D_OUT = {1'b0, inmode[i], 1'b0, oneshot[i],
                                     outmode[i], pbon[i], start[i]};
                        end
                        for (int k = 0; k < NB; k++) begin
                            if (rsel == 3'(k)) begin
                                D_OUT = count[i][8*k +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
